// File: rtl/stream_credit_rx.sv
// Receive end of a fixed-latency, no-backpressure stream link. Credits gate the link
// ready, arrivals land in a first-word-fall-through FIFO, and protocol errors are flagged.
module stream_credit_rx #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       req_o,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       spurious_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (LATENCY > 0) ? LATENCY : 1;
  localparam int SW = $clog2(DEPTH + LATENCY + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [HW-1:0]    hist;
  logic [SW-1:0]    inflight;
  logic             due;
  logic             full;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outstanding credits are the stored items plus every grant still in the link.
  always_comb begin
    inflight = SW'(count);
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SW'(hist[i]);
    end
  end

  assign req_o     = !reset && (inflight < SW'(DEPTH));
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign out_data  = mem[rd_ptr];
  assign count_o   = count;

  generate
    if (LATENCY == 0) begin : g_no_hist
      assign hist = '0;
      assign due  = 1'b1;
    end else if (LATENCY == 1) begin : g_hist1
      always_ff @(posedge clk) begin
        if (reset) hist <= '0;
        else       hist <= req_o;
      end
      assign due = hist[0];
    end else begin : g_histn
      always_ff @(posedge clk) begin
        if (reset) hist <= '0;
        else       hist <= {hist[HW-2:0], req_o};
      end
      assign due = hist[HW-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_valid && full && !pop) overflow_o <= 1'b1;
      if (in_valid && !due)         spurious_o <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
